ehl_fifo_rc_fwft: RTL and testbench

- Next-generation read-side controller for the dual-clock FIFO, in the rclk domain.
- Converts the already-synchronised write gray pointer into a fill level.
- Drives the memory read port and publishes a registered gray read pointer back to the write domain.
- Adds a selectable first-word-fall-through (FWFT) mode with a 2-entry prefetch/skid stage, a runtime almost-empty threshold, a read level output and a sticky underflow flag.

---
 rtl/ehl_fifo_rc_fwft.sv | 192 +++++++++++++++++++
 tb/tb_ehl_fifo_rc_fwft.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ehl_fifo_rc_fwft.sv
// ehl_fifo_rc_fwft: read-side controller of a dual-clock FIFO, rclk domain.
// Turns the synchronised write gray pointer into a fill level, drives the
// memory read port and returns a registered gray read pointer to the write
// side. With FWFT=1 the head word is prefetched into an output register
// backed by a one-word skid register, so rdata is valid before the pop.
module ehl_fifo_rc_fwft #(
  parameter int ADR_WIDTH  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = 1,
  parameter int RAM_LAT    = 1
) (
  input  logic                  rclk,
  input  logic                  reset_n,
  input  logic                  rd,
  input  logic                  clr_uf,
  input  logic [ADR_WIDTH:0]    wptr_gray,
  input  logic [ADR_WIDTH:0]    aempty_thr,
  output logic [ADR_WIDTH:0]    rptr_gray,
  output logic [ADR_WIDTH-1:0]  raddr,
  output logic                  ren,
  input  logic [DATA_WIDTH-1:0] rdata_mem,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  r_empty,
  output logic                  r_aempty,
  output logic                  r_full,
  output logic [ADR_WIDTH:0]    r_level,
  output logic                  r_underflow
);

  localparam int PW = ADR_WIDTH + 1;
  localparam logic [ADR_WIDTH:0] DEPTH_C = {1'b1, {ADR_WIDTH{1'b0}}};
  localparam logic [ADR_WIDTH:0] ZERO_C  = {PW{1'b0}};

  // The staging logic assumes data returns exactly one cycle after ren.
  if (RAM_LAT != 1) begin : g_bad_ram_lat
    $error("ehl_fifo_rc_fwft: only RAM_LAT = 1 is supported");
  end

  if ((ADR_WIDTH < 1) || (ADR_WIDTH > 16)) begin : g_bad_adr_width
    $error("ehl_fifo_rc_fwft: ADR_WIDTH must be in 1..16");
  end

  function automatic logic [ADR_WIDTH:0] bin2gray(input logic [ADR_WIDTH:0] bin);
    return bin ^ {1'b0, bin[ADR_WIDTH:1]};
  endfunction

  function automatic logic [ADR_WIDTH:0] gray2bin(input logic [ADR_WIDTH:0] gray);
    logic [ADR_WIDTH:0] bin;
    bin[ADR_WIDTH] = gray[ADR_WIDTH];
    for (int i = ADR_WIDTH - 1; i >= 0; i--) begin
      bin[i] = bin[i + 1] ^ gray[i];
    end
    return bin;
  endfunction

  // Registered state
  logic [ADR_WIDTH:0]    rptr_bin_r;
  logic [ADR_WIDTH:0]    rptr_gray_r;
  logic [DATA_WIDTH-1:0] out_r;
  logic [DATA_WIDTH-1:0] skid_r;
  logic                  out_v_r;
  logic                  skid_v_r;
  logic                  infl_r;
  logic                  uf_r;

  // Combinational terms
  logic [ADR_WIDTH:0]    wptr_bin_s;
  logic [ADR_WIDTH:0]    mem_level_s;
  logic                  mem_empty_s;
  logic [ADR_WIDTH:0]    rptr_bin_next_s;
  logic [1:0]            occ_s;
  logic                  pop_s;
  logic                  ren_s;
  logic                  empty_s;
  logic [ADR_WIDTH:0]    level_s;
  logic [DATA_WIDTH-1:0] out_d_s;
  logic [DATA_WIDTH-1:0] skid_d_s;
  logic                  out_v_d_s;
  logic                  skid_v_d_s;
  logic                  uf_d_s;

  // Level, flags and the read-enable decision for the selected mode.
  always_comb begin
    wptr_bin_s      = gray2bin(wptr_gray);
    mem_level_s     = wptr_bin_s - rptr_bin_r;
    mem_empty_s     = (mem_level_s == ZERO_C);
    occ_s           = {1'b0, out_v_r} + {1'b0, skid_v_r} + {1'b0, infl_r};
    if (FWFT != 0) begin
      pop_s   = rd & out_v_r;
      ren_s   = ~mem_empty_s & ((occ_s - {1'b0, pop_s}) < 2'd2);
      empty_s = ~out_v_r;
      level_s = mem_level_s + PW'(occ_s);
    end else begin
      pop_s   = 1'b0;
      ren_s   = rd & ~mem_empty_s;
      empty_s = mem_empty_s;
      level_s = mem_level_s;
    end
    rptr_bin_next_s = rptr_bin_r + PW'(ren_s);
  end

  // Next-state of the output/skid stage; skid drains before returning data
  // so words leave in FIFO order.
  always_comb begin
    out_d_s    = out_r;
    skid_d_s   = skid_r;
    out_v_d_s  = out_v_r;
    skid_v_d_s = skid_v_r;
    if (FWFT != 0) begin
      if (skid_v_r) begin
        if (pop_s) begin
          out_d_s   = skid_r;
          out_v_d_s = 1'b1;
          if (infl_r) begin
            skid_d_s   = rdata_mem;
            skid_v_d_s = 1'b1;
          end else begin
            skid_v_d_s = 1'b0;
          end
        end else begin
          out_v_d_s = out_v_r;
        end
      end else if (infl_r) begin
        if (~out_v_r | pop_s) begin
          out_d_s   = rdata_mem;
          out_v_d_s = 1'b1;
        end else begin
          skid_d_s   = rdata_mem;
          skid_v_d_s = 1'b1;
        end
      end else if (pop_s) begin
        out_v_d_s = 1'b0;
      end else begin
        out_v_d_s = out_v_r;
      end
    end else begin
      out_v_d_s = infl_r;
      if (infl_r) begin
        out_d_s = rdata_mem;
      end else begin
        out_d_s = out_r;
      end
    end
  end

  // Sticky underflow: clear wins over a same-cycle set.
  always_comb begin
    if (clr_uf) begin
      uf_d_s = 1'b0;
    end else if (rd & empty_s) begin
      uf_d_s = 1'b1;
    end else begin
      uf_d_s = uf_r;
    end
  end

  // State registers; reset flushes every staged word and the read pointer.
  always_ff @(posedge rclk or negedge reset_n) begin
    if (!reset_n) begin
      rptr_bin_r  <= ZERO_C;
      rptr_gray_r <= ZERO_C;
      out_r       <= {DATA_WIDTH{1'b0}};
      skid_r      <= {DATA_WIDTH{1'b0}};
      out_v_r     <= 1'b0;
      skid_v_r    <= 1'b0;
      infl_r      <= 1'b0;
      uf_r        <= 1'b0;
    end else begin
      rptr_bin_r  <= rptr_bin_next_s;
      rptr_gray_r <= bin2gray(rptr_bin_next_s);
      out_r       <= out_d_s;
      skid_r      <= skid_d_s;
      out_v_r     <= out_v_d_s;
      skid_v_r    <= skid_v_d_s;
      infl_r      <= ren_s;
      uf_r        <= uf_d_s;
    end
  end

  assign rptr_gray   = rptr_gray_r;
  assign raddr       = rptr_bin_r[ADR_WIDTH-1:0];
  assign ren         = ren_s;
  assign rdata       = out_r;
  assign rvalid      = out_v_r;
  assign r_empty     = empty_s;
  assign r_level     = level_s;
  assign r_aempty    = (level_s <= aempty_thr);
  assign r_full      = (mem_level_s == DEPTH_C);
  assign r_underflow = uf_r;

endmodule

// File: tb/tb_ehl_fifo_rc_fwft.sv
// Bench for ehl_fifo_rc_fwft: one FWFT instance and one standard instance,
// each with its own RAM model, checked against queue-based reference models.
module tb_ehl_fifo_rc_fwft;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int PW = AW + 1;

  logic rclk = 1'b0;
  logic reset_n = 1'b0;
  always #5 rclk = ~rclk;

  // FWFT instance signals
  logic          f_rd, f_clr_uf, f_ren, f_rvalid, f_r_empty, f_r_aempty, f_r_full, f_r_underflow;
  logic [PW-1:0] f_wptr_gray, f_thr, f_rptr_gray, f_r_level;
  logic [AW-1:0] f_raddr;
  logic [DW-1:0] f_rdata_mem, f_rdata;
  // Standard instance signals
  logic          s_rd, s_clr_uf, s_ren, s_rvalid, s_r_empty, s_r_aempty, s_r_full, s_r_underflow;
  logic [PW-1:0] s_wptr_gray, s_thr, s_rptr_gray, s_r_level;
  logic [AW-1:0] s_raddr;
  logic [DW-1:0] s_rdata_mem, s_rdata;

  ehl_fifo_rc_fwft #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1), .RAM_LAT(1)) u_fwft (
    .rclk(rclk), .reset_n(reset_n), .rd(f_rd), .clr_uf(f_clr_uf),
    .wptr_gray(f_wptr_gray), .aempty_thr(f_thr), .rptr_gray(f_rptr_gray),
    .raddr(f_raddr), .ren(f_ren), .rdata_mem(f_rdata_mem), .rdata(f_rdata),
    .rvalid(f_rvalid), .r_empty(f_r_empty), .r_aempty(f_r_aempty), .r_full(f_r_full),
    .r_level(f_r_level), .r_underflow(f_r_underflow)
  );

  ehl_fifo_rc_fwft #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0), .RAM_LAT(1)) u_std (
    .rclk(rclk), .reset_n(reset_n), .rd(s_rd), .clr_uf(s_clr_uf),
    .wptr_gray(s_wptr_gray), .aempty_thr(s_thr), .rptr_gray(s_rptr_gray),
    .raddr(s_raddr), .ren(s_ren), .rdata_mem(s_rdata_mem), .rdata(s_rdata),
    .rvalid(s_rvalid), .r_empty(s_r_empty), .r_aempty(s_r_aempty), .r_full(s_r_full),
    .r_level(s_r_level), .r_underflow(s_r_underflow)
  );

  // Synchronous RAMs with one cycle read latency
  logic [DW-1:0] f_mem [16];
  logic [DW-1:0] s_mem [16];
  always @(posedge rclk) if (f_ren) f_rdata_mem <= f_mem[f_raddr];
  always @(posedge rclk) if (s_ren) s_rdata_mem <= s_mem[s_raddr];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] f_q [$];
  logic [DW-1:0] s_q [$];
  int            f_wcnt = 0;
  int            s_wcnt = 0;
  logic          f_uf = 1'b0;
  logic          s_uf = 1'b0;
  logic          s_p1v = 1'b0, s_p2v = 1'b0;
  logic [DW-1:0] s_p1d = 8'h00, s_p2d = 8'h00, s_last = 8'h00;

  logic [2:0] std_steps [6] = '{3'b110, 3'b010, 3'b000, 3'b000, 3'b011, 3'b000};
  logic       ren_tab   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic       rv_tab    [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  function automatic logic [PW-1:0] to_gray(input int n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  function automatic int from_gray(input logic [PW-1:0] g);
    int b;
    b = 0;
    for (int i = 0; i < PW; i++) b = b ^ (int'(g) >> i);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic f_write(input logic [DW-1:0] d);
    f_mem[4'(f_wcnt)] = d;
    f_q.push_back(d);
    f_wcnt++;
    f_wptr_gray = to_gray(f_wcnt);
  endtask

  task automatic s_write(input logic [DW-1:0] d);
    s_mem[4'(s_wcnt)] = d;
    s_q.push_back(d);
    s_wcnt++;
    s_wptr_gray = to_gray(s_wcnt);
  endtask

  // Checks common to every FWFT cycle: level, flags and head-of-queue data
  task automatic f_common();
    chk("f_level", 32'(f_r_level), f_q.size());
    chk("f_empty_vs_rvalid", 32'(f_r_empty), 32'(!f_rvalid));
    chk("f_aempty", 32'(f_r_aempty), 32'(f_q.size() <= int'(f_thr)));
    if (f_q.size() == 0) chk("f_spurious_rvalid", 32'(f_rvalid), 32'(1'b0));
    else if (f_rvalid) chk("f_rdata", 32'(f_rdata), 32'(f_q[0]));
  endtask

  // One standard-mode cycle: compare against the model, then advance it
  task automatic s_cycle();
    logic          popv;
    logic [DW-1:0] popd;
    chk("s_level", 32'(s_r_level), s_q.size());
    chk("s_full", 32'(s_r_full), 32'(s_q.size() == 16));
    chk("s_aempty", 32'(s_r_aempty), 32'(s_q.size() <= int'(s_thr)));
    chk("s_empty", 32'(s_r_empty), 32'(s_q.size() == 0));
    chk("s_ren", 32'(s_ren), 32'(s_rd && (s_q.size() > 0)));
    chk("s_rvalid", 32'(s_rvalid), 32'(s_p2v));
    chk("s_rdata", 32'(s_rdata), 32'(s_p2v ? s_p2d : s_last));
    chk("s_underflow", 32'(s_r_underflow), 32'(s_uf));
    popv = s_rd && (s_q.size() > 0);
    popd = 8'h00;
    if (popv) begin
      popd = s_q[0];
      s_q.delete(0);
    end
    if (s_p2v) s_last = s_p2d;
    s_p2v = s_p1v; s_p2d = s_p1d;
    s_p1v = popv;  s_p1d = popd;
    if (s_clr_uf) s_uf = 1'b0;
    else if (s_rd && !popv) s_uf = 1'b1;
  endtask

  initial begin
    logic [PW-1:0] prev_g;
    int            written, popped, stall;
    logic          wrapped;

    f_rd = 1'b0; f_clr_uf = 1'b0; f_wptr_gray = 5'd0; f_thr = 5'd2;
    s_rd = 1'b0; s_clr_uf = 1'b0; s_wptr_gray = 5'd0; s_thr = 5'd4;

    // Reset state
    repeat (2) @(posedge rclk);
    #2;
    chk("rst_f_empty", 32'(f_r_empty), 32'(1'b1));
    chk("rst_f_rvalid", 32'(f_rvalid), 32'(1'b0));
    chk("rst_f_level", 32'(f_r_level), 32'd0);
    chk("rst_f_rptr_gray", 32'(f_rptr_gray), 32'd0);
    chk("rst_f_underflow", 32'(f_r_underflow), 32'(1'b0));
    chk("rst_f_ren", 32'(f_ren), 32'(1'b0));
    chk("rst_f_rdata", 32'(f_rdata), 32'd0);
    chk("rst_f_aempty", 32'(f_r_aempty), 32'(1'b1));
    chk("rst_s_full", 32'(s_r_full), 32'(1'b0));
    chk("rst_s_rvalid", 32'(s_rvalid), 32'(1'b0));
    @(negedge rclk);
    reset_n = 1'b1;

    // FWFT: three words arrive, prefetch fills output and skid without rd
    tick();
    for (int i = 0; i < 3; i++) f_write(8'($urandom));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      #1;
      chk("f_fill_ren", 32'(f_ren), 32'(ren_tab[k]));
      chk("f_fill_rvalid", 32'(f_rvalid), 32'(rv_tab[k]));
      f_common();
    end

    // FWFT: back-to-back pops with no bubble, then empty
    for (int k = 0; k < 4; k++) begin
      tick();
      f_rd = (k < 3);
      #1;
      if (k < 3) chk("f_pop_rvalid", 32'(f_rvalid), 32'(1'b1));
      else chk("f_drained_empty", 32'(f_r_empty), 32'(1'b1));
      f_common();
      if (f_rd && f_rvalid) f_q.delete(0);
    end
    tick();
    f_rd = 1'b0;

    // Standard mode: single word, underflow, clear with priority
    for (int k = 0; k < 6; k++) begin
      tick();
      if (std_steps[k][2]) s_write(8'($urandom));
      s_rd = std_steps[k][1];
      s_clr_uf = std_steps[k][0];
      #1;
      s_cycle();
    end

    // Standard mode: fill to full, then drain through the almost-empty threshold
    for (int k = 0; k < 35; k++) begin
      tick();
      if (k < 16) s_write(8'($urandom));
      s_rd = (k >= 16) && (k < 32);
      s_clr_uf = 1'b0;
      #1;
      s_cycle();
    end

    // FWFT: 40 random words with random pops, across the pointer wrap
    tick();
    s_rd = 1'b0;
    f_thr = 5'($urandom_range(0, 16));
    prev_g = f_rptr_gray;
    written = 0; popped = 0; stall = 0; wrapped = 1'b0;
    for (int cyc = 0; (cyc < 2000) && (popped < 40); cyc++) begin
      tick();
      if ((written < 40) && (f_q.size() < 16) && ($urandom_range(0, 2) != 0)) begin
        f_write(8'($urandom));
        written++;
      end
      f_rd = ($urandom_range(0, 3) != 0);
      f_clr_uf = ($urandom_range(0, 15) == 0);
      #1;
      f_common();
      chk("f_underflow", 32'(f_r_underflow), 32'(f_uf));
      chk("f_gray_one_bit", 32'($countones(prev_g ^ f_rptr_gray) <= 1), 32'(1'b1));
      if ((from_gray(prev_g) == 31) && (from_gray(f_rptr_gray) == 0)) wrapped = 1'b1;
      prev_g = f_rptr_gray;
      if ((f_q.size() > 0) && !f_rvalid) stall++;
      else stall = 0;
      chk("f_first_word_latency", 32'(stall <= 2), 32'(1'b1));
      if (f_clr_uf) f_uf = 1'b0;
      else if (f_rd && !f_rvalid) f_uf = 1'b1;
      if (f_rd && f_rvalid) begin
        f_q.delete(0);
        popped++;
      end
    end
    chk("f_stream_popped", popped, 32'd40);
    chk("f_rptr_wrapped", 32'(wrapped), 32'(1'b1));
    tick();
    f_rd = 1'b0;
    f_clr_uf = 1'b1;
    repeat (3) tick();
    f_clr_uf = 1'b0;
    #1;
    chk("f_rptr_final", from_gray(f_rptr_gray), f_wcnt % 32);
    chk("f_level_final", 32'(f_r_level), 32'd0);

    // FWFT: reset while output and skid hold words and memory is not empty
    tick();
    for (int i = 0; i < 4; i++) f_write(8'($urandom));
    repeat (3) tick();
    #1;
    chk("f_pre_reset_rvalid", 32'(f_rvalid), 32'(1'b1));
    chk("f_pre_reset_level", 32'(f_r_level), 32'd4);
    tick();
    reset_n = 1'b0;
    tick();
    #1;
    chk("f_midrst_rvalid", 32'(f_rvalid), 32'(1'b0));
    chk("f_midrst_empty", 32'(f_r_empty), 32'(1'b1));
    chk("f_midrst_level", 32'(f_r_level), f_wcnt % 32);
    chk("f_midrst_rptr_gray", 32'(f_rptr_gray), 32'd0);
    chk("f_midrst_rdata", 32'(f_rdata), 32'd0);
    @(negedge rclk);
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
